// File: rtl/crc_scr_framer.sv
// crc_scr_framer: byte-in, bit-serial TX framer, MSB-first payload + CRC-16 trailer; FRAME_SCR_EN adds the 1+x^14+x^15 PRBS scrambler.
// Latency: a byte accepted at edge N is on odat at edge N+1 when the shifter is idle; 1 bit/clk sustained.
// Backpressure: !irdy freezes the output register; ordy = holding register free (or being emptied this cycle).
module crc_scr_framer #(
    parameter int unsigned pPAYLOAD_BYTES = 238,
    parameter logic [15:0] pCRC_INIT      = 16'hFFFF
`ifdef FRAME_SCR_EN
    ,
    parameter logic [14:0] pSCR_SEED      = 15'b100101010000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] idat,
    input  logic       ival,
    output logic       ordy,
    input  logic       irdy,
    output logic       oval,
    output logic       odat,
    output logic       osop,
    output logic       oeop,
    output logic       obusy
);
    typedef enum logic [1:0] {ST_IDLE, ST_PAY, ST_CRC} state_t;

    localparam logic [9:0]  LP_LAST_BYTE = 10'(pPAYLOAD_BYTES - 1);
    localparam logic [15:0] LP_CRC_POLY  = 16'h1021;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hold_dat;
    logic        r_hold_vld;
    logic [6:0]  r_shf_dat;
    logic [2:0]  r_shf_cnt;
    logic [2:0]  r_bit_cnt;
    logic [9:0]  r_byte_cnt;
    logic [3:0]  r_crc_cnt;
    logic [15:0] r_crc;
    logic        r_oval;
    logic        r_odat;
    logic        r_osop;
    logic        r_oeop;
    logic        r_busy;

    logic        w_crc_ph;
    logic        w_out_free;
    logic        w_have_bit;
    logic        w_ld;
    logic        w_ld_pay;
    logic        w_ld_crc;
    logic        w_take_hold;
    logic        w_raw_bit;
    logic        w_pay_bit;
    logic        w_obit;
    logic        w_last_pay;
    logic        w_last_crc;
    logic        w_acc;
    logic        w_eop_xfer;
    logic        w_crc_fb;
    logic [15:0] w_crc_upd;

    // Counters, scrambler and CRC step when a bit enters the output register;
    // that bit then stays put until irdy takes it, so each step maps to exactly one transfer.
    assign w_crc_ph    = (r_state == ST_CRC);
    assign w_out_free  = !r_oval || irdy;
    assign w_have_bit  = w_crc_ph || (r_shf_cnt != 3'd0) || r_hold_vld;
    assign w_ld        = w_out_free && w_have_bit;
    assign w_ld_pay    = w_ld && !w_crc_ph;
    assign w_ld_crc    = w_ld && w_crc_ph;
    assign w_take_hold = w_ld_pay && (r_shf_cnt == 3'd0);
    assign w_raw_bit   = (r_shf_cnt != 3'd0) ? r_shf_dat[6] : r_hold_dat[7];
    assign w_last_pay  = (r_bit_cnt == 3'd7) && (r_byte_cnt == LP_LAST_BYTE);
    assign w_last_crc  = (r_crc_cnt == 4'd15);
    assign w_acc       = ival && ordy;
    assign w_eop_xfer  = r_oval && r_oeop && irdy;

`ifdef FRAME_SCR_EN
    logic [14:0] r_scr;
    logic        w_prbs;

    assign w_prbs    = r_scr[14] ^ r_scr[13];
    assign w_pay_bit = w_raw_bit ^ w_prbs;

    // Reseeding at frame end means the next frame starts from the seed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scr <= pSCR_SEED;
        end else if (w_ld_crc && w_last_crc) begin
            r_scr <= pSCR_SEED;
        end else if (w_ld_pay) begin
            r_scr <= {r_scr[13:0], w_prbs};
        end
    end
`else
    assign w_pay_bit = w_raw_bit;
`endif

    assign w_crc_fb  = r_crc[15] ^ w_pay_bit;
    assign w_crc_upd = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? LP_CRC_POLY : 16'h0000);
    assign w_obit    = w_crc_ph ? r_crc[15] : w_pay_bit;

    assign ordy  = !r_hold_vld || w_take_hold;
    assign oval  = r_oval;
    assign odat  = r_odat;
    assign osop  = r_osop;
    assign oeop  = r_oeop;
    assign obusy = r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_hold_vld) w_state_nxt = ST_PAY;
            ST_PAY:  if (w_ld_pay && w_last_pay) w_state_nxt = ST_CRC;
            ST_CRC:  if (w_ld_crc && w_last_crc) w_state_nxt = r_hold_vld ? ST_PAY : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_dat <= 8'h00;
            r_hold_vld <= 1'b0;
            r_shf_dat  <= 7'h00;
            r_shf_cnt  <= 3'd0;
        end else begin
            if (w_acc) begin
                r_hold_dat <= idat;
                r_hold_vld <= 1'b1;
            end else if (w_take_hold) begin
                r_hold_vld <= 1'b0;
            end
            if (w_take_hold) begin
                r_shf_dat <= r_hold_dat[6:0];
                r_shf_cnt <= 3'd7;
            end else if (w_ld_pay) begin
                r_shf_dat <= {r_shf_dat[5:0], 1'b0};
                r_shf_cnt <= r_shf_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 10'd0;
            r_crc_cnt  <= 4'd0;
            r_crc      <= pCRC_INIT;
        end else begin
            if (w_ld_pay) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_cnt <= w_last_pay ? 10'd0 : r_byte_cnt + 10'd1;
                end
                r_crc <= w_crc_upd;
            end else if (w_ld_crc) begin
                r_crc_cnt <= r_crc_cnt + 4'd1;
                r_crc     <= w_last_crc ? pCRC_INIT : {r_crc[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oval <= 1'b0;
            r_odat <= 1'b0;
            r_osop <= 1'b0;
            r_oeop <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            if (w_ld) begin
                r_oval <= 1'b1;
                r_odat <= w_obit;
                r_osop <= w_ld_pay && (r_bit_cnt == 3'd0) && (r_byte_cnt == 10'd0);
                r_oeop <= w_ld_crc && w_last_crc;
            end else if (irdy) begin
                r_oval <= 1'b0;
                r_osop <= 1'b0;
                r_oeop <= 1'b0;
            end
            // Only a pre-loaded first byte of the next frame can be waiting when eop leaves.
            if (w_acc) begin
                r_busy <= 1'b1;
            end else if (w_eop_xfer) begin
                r_busy <= r_hold_vld;
            end
        end
    end

endmodule

// File: tb/tb_crc_scr_framer.sv
// Bench for crc_scr_framer: directed sequence with random traffic against a bit-array model of the frame.
module tb_crc_scr_framer;
    localparam int NB   = 9;
    localparam int FLEN = 8 * NB + 16;
    localparam int BUDGET = 5000;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [14:0] SCR_SEED = 15'b100101010000000;
    localparam logic [16:0] POLY17   = 17'h11021;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] idat = 8'h00;
    logic       ival = 1'b0;
    logic       irdy = 1'b0;
    logic       ordy, oval, odat, osop, oeop, obusy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic       rx_dat[$];
    logic       rx_sop[$];
    logic       rx_eop[$];
    int         rx_cyc[$];
    int         acc_cyc[$];
    logic       exp_q[$];
    logic [7:0] tx_q[$];

    crc_scr_framer #(.pPAYLOAD_BYTES(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .idat  (idat),
        .ival  (ival),
        .ordy  (ordy),
        .irdy  (irdy),
        .oval  (oval),
        .odat  (odat),
        .osop  (osop),
        .oeop  (oeop),
        .obusy (obusy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && oval && irdy) begin
            rx_dat.push_back(odat);
            rx_sop.push_back(osop);
            rx_eop.push_back(oeop);
            rx_cyc.push_back(cyc);
        end
        if (rst && ival && ordy) acc_cyc.push_back(cyc);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks made", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_tests++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, req);
        end
    endtask

    // Frame = payload bits (optionally XOR PRBS sequence) followed by the CRC remainder,
    // found by long division of the init-adjusted message by x^16+x^12+x^5+1.
    function automatic void model_frame(input logic [7:0] pay[$]);
        int   L = pay.size() * 8;
        logic m[$];
        logic a[$];
        logic [15:0] ini = CRC_INIT;
        logic [16:0] g   = POLY17;
`ifdef FRAME_SCR_EN
        logic y[$];
        logic [14:0] sd = SCR_SEED;
`endif
        for (int i = 0; i < pay.size(); i++)
            for (int k = 7; k >= 0; k--) m.push_back(pay[i][k]);
`ifdef FRAME_SCR_EN
        for (int k = 14; k >= 0; k--) y.push_back(sd[k]);
        for (int n = 0; n < L; n++) begin
            y.push_back(y[n] ^ y[n+1]);
            m[n] = m[n] ^ y[n+15];
        end
`endif
        a = m;
        for (int k = 0; k < 16; k++) a.push_back(1'b0);
        for (int k = 0; k < 16; k++) a[k] = a[k] ^ ini[15-k];
        for (int i = 0; i < L; i++)
            if (a[i]) for (int k = 0; k < 17; k++) a[i+k] = a[i+k] ^ g[16-k];
        for (int i = 0; i < L; i++) exp_q.push_back(m[i]);
        for (int k = 0; k < 16; k++) exp_q.push_back(a[L+k]);
    endfunction

    task automatic model_all(input int nfr);
        logic [7:0] fr[$];
        for (int f = 0; f < nfr; f++) begin
            fr.delete();
            for (int i = 0; i < NB; i++) fr.push_back(tx_q[f*NB+i]);
            model_frame(fr);
        end
    endtask

    task automatic clear_all();
        rx_dat.delete(); rx_sop.delete(); rx_eop.delete(); rx_cyc.delete();
        acc_cyc.delete(); exp_q.delete(); tx_q.delete();
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic fill_ascii();
        for (int i = 0; i < NB; i++) tx_q.push_back(8'h31 + 8'(i));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ordy"},  {31'd0, ordy},  1);
        chk({tag, " oval"},  {31'd0, oval},  0);
        chk({tag, " odat"},  {31'd0, odat},  0);
        chk({tag, " osop"},  {31'd0, osop},  0);
        chk({tag, " oeop"},  {31'd0, oeop},  0);
        chk({tag, " obusy"}, {31'd0, obusy}, 0);
    endtask

    task automatic run_stream(input int ival_pct, input int irdy_pct, input int nbits,
                              input int stall_at, input string tag);
        int idx = 0;
        int n   = 0;
        bit stalled = 1'b0;
        while (rx_dat.size() < nbits && n < BUDGET) begin
            if (stall_at >= 0 && !stalled && rx_dat.size() >= stall_at) begin
                int pos = rx_dat.size();
                int bad = 0;
                stalled = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    irdy = 1'b0;
                    ival = (idx < tx_q.size());
                    if (ival) idat = tx_q[idx];
                    @(negedge clk);
                    if (oval !== 1'b1 || odat !== exp_q[pos] ||
                        osop !== ((pos % FLEN) == 0) || oeop !== ((pos % FLEN) == FLEN - 1)) bad++;
                    if (ival && ordy) idx++;
                    @(posedge clk); #1;
                end
                chk({tag, " stall outputs held"}, bad, 0);
                chk({tag, " ordy low while held"}, {31'd0, ordy}, 0);
                chk({tag, " obusy mid-frame"}, {31'd0, obusy}, 1);
                chk({tag, " no transfer while stalled"}, rx_dat.size(), pos);
            end
            ival = (idx < tx_q.size()) && ($urandom_range(99) < ival_pct);
            if (ival) idat = tx_q[idx];
            else      idat = 8'($urandom);
            irdy = ($urandom_range(99) < irdy_pct);
            @(negedge clk);
            if (ival && ordy) idx++;
            @(posedge clk); #1;
            n++;
        end
        ival = 1'b0;
        irdy = 1'b0;
        chk({tag, " finished within budget"}, {31'd0, n < BUDGET}, 1);
    endtask

    task automatic check_frames(input string tag, input int nfr);
        int bad_d = 0;
        int bad_m = 0;
        int nsop  = 0;
        int neop  = 0;
        int n = (rx_dat.size() < exp_q.size()) ? rx_dat.size() : exp_q.size();
        chk({tag, " transfer count"}, rx_dat.size(), nfr * FLEN);
        for (int i = 0; i < n; i++) begin
            if (rx_dat[i] !== exp_q[i]) bad_d++;
            if (rx_sop[i] !== ((i % FLEN) == 0)) bad_m++;
            if (rx_eop[i] !== ((i % FLEN) == FLEN - 1)) bad_m++;
            nsop += (rx_sop[i] === 1'b1) ? 1 : 0;
            neop += (rx_eop[i] === 1'b1) ? 1 : 0;
        end
        chk({tag, " bit mismatches"}, bad_d, 0);
        chk({tag, " marker mismatches"}, bad_m, 0);
        chk({tag, " osop count"}, nsop, nfr);
        chk({tag, " oeop count"}, neop, nfr);
    endtask

    task automatic chk_ascii_crc(input string tag);
`ifndef FRAME_SCR_EN
        logic [15:0] w = 16'h0000;
        logic [7:0]  b0 = 8'h00;
        for (int k = 0; k < 16; k++) w = {w[14:0], rx_dat[8*NB+k]};
        for (int k = 0; k < 8; k++) b0 = {b0[6:0], rx_dat[k]};
        chk({tag, " crc word"}, {16'd0, w}, 32'h29B1);
        chk({tag, " first byte"}, {24'd0, b0}, 32'h31);
`else
        chk({tag, " frame length"}, rx_dat.size(), FLEN);
`endif
    endtask

    initial begin
        logic [7:0] ba, bb;

        // Reset state
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: ASCII vector at full rate
        clear_all();
        fill_ascii();
        model_all(1);
        run_stream(100, 100, FLEN, -1, "t1");
        check_frames("t1", 1);
        chk_ascii_crc("t1");
        chk("t1 consecutive oval", rx_cyc[FLEN-1] - rx_cyc[0], FLEN - 1);
        chk("t1 first-bit latency", rx_cyc[0] - acc_cyc[0], 2);
        chk("t1 obusy after frame", {31'd0, obusy}, 0);

        // 2: two all-zero frames back to back
        clear_all();
        for (int i = 0; i < 2 * NB; i++) tx_q.push_back(8'h00);
        model_all(2);
        run_stream(100, 100, 2 * FLEN, -1, "t2");
        check_frames("t2", 2);
        chk("t2 sop follows eop", rx_cyc[FLEN] - rx_cyc[FLEN-1], 1);

        // 3: three frames, random gaps on both sides
        clear_all();
        fill_random(3 * NB);
        model_all(3);
        run_stream(70, 50, 3 * FLEN, -1, "t3");
        check_frames("t3", 3);

        // 4: long stall mid-payload
        clear_all();
        fill_random(NB);
        model_all(1);
        run_stream(100, 100, FLEN, 20, "t4");
        check_frames("t4", 1);

        // 5: reset mid-frame, then replay the ASCII vector
        clear_all();
        fill_random(NB);
        run_stream(100, 100, 36, -1, "t5a");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t5 in reset");
        @(posedge clk); #1;
        rst = 1'b1;
        clear_all();
        fill_ascii();
        model_all(1);
        run_stream(100, 100, FLEN, -1, "t5");
        check_frames("t5", 1);
        chk_ascii_crc("t5");

        // 6: byte offered while the holding register is full must be ignored
        clear_all();
        ba = 8'($urandom);
        bb = 8'($urandom);
        irdy = 1'b0;
        ival = 1'b1;
        idat = ba;
        @(negedge clk);
        chk("t6 ordy when empty", {31'd0, ordy}, 1);
        @(posedge clk); #1;
        idat = bb;
        @(negedge clk);
        chk("t6 refill while shifter loads", {31'd0, ordy}, 1);
        @(posedge clk); #1;
        idat = ~bb;
        @(negedge clk);
        chk("t6 ordy when full", {31'd0, ordy}, 0);
        @(posedge clk); #1;
        ival = 1'b0;
        tx_q.push_back(ba);
        tx_q.push_back(bb);
        fill_random(NB - 2);
        model_all(1);
        tx_q.delete(0);
        tx_q.delete(0);
        run_stream(100, 100, FLEN, -1, "t6");
        check_frames("t6", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_scr_framer.md
# crc_scr_framer

Transmit-side framer for the modem TX chain. It is the counterpart of the RX CRC-decoder/descrambler pair.
- Accepts payload bytes and serialises them MSB-first.
- Optionally scrambles each bit with the WiMAX PRBS.
- Appends a CRC-16 computed over the transmitted payload bits.
- Emits a bit-serial frame with sop/eop markers toward the LDPC encoder input packer.

## Interface
- pPAYLOAD_BYTES, 238, payload bytes per frame (238*8+16 = 1920 bits = LDPC k for pN 2304, rate 5/6); legal range 1..1023
- pCRC_INIT, 16'hFFFF, CRC register value at each frame start
- pSCR_SEED, 15'b100101010000000, scrambler state at each frame start
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset; all state and outputs are cleared while rst = 0
- idat  input  8  payload byte
- ival  input  1  idat valid
- ordy  output  1  byte accepted on a clk edge where ival && ordy
- irdy  input  1  downstream ready; an output bit transfers on a clk edge where oval && irdy
- oval  output  1  odat valid
- odat  output  1  serial frame bit
- osop  output  1  first bit of frame, qualified by oval
- oeop  output  1  last CRC bit of frame, qualified by oval
- obusy  output  1  frame in progress (first byte accepted through oeop transfer)

## Operation
**Datapath**
- One-byte holding register, then an 8-bit shifter, then a registered output stage.
- ordy = holding register empty. The holding register refills in the same cycle the shifter loads from it.

**Frame counters**
- bit counter: 0..7
- byte counter: 0..pPAYLOAD_BYTES-1
- crc counter: 0..15

**FSM states**
- IDLE → PAY when a byte is present in the holding register.
- PAY → CRC after bit 7 of byte pPAYLOAD_BYTES-1 is transferred.
- CRC → PAY after the 16th CRC bit is transferred, if the holding register is full.
- CRC → IDLE after the 16th CRC bit is transferred, if the holding register is empty.

**Scrambler (PAY only)**
- Polynomial 1+x^14+x^15, state s[14:0], reloaded with pSCR_SEED at every frame start.
- prbs = s[14]^s[13].
- Output bit = data_bit ^ prbs.
- On each payload bit transfer, s <= {s[13:0], prbs}.

**CRC-16**
- Polynomial 0x1021, non-reflected, no final XOR, register reloaded with pCRC_INIT at every frame start.
- Updated with each transmitted (post-scramble) payload bit.
- In CRC state the register is shifted out MSB-first and is not scrambled.

**Flow control and boundaries**
- Payload underrun (shifter empty, no byte held) drops oval mid-frame. Frame position is kept and resumes on the next byte.
- The next frame's first byte may be accepted during CRC state. Its osop bit then follows oeop with no gap.
- osop is set only on bit 0 of byte 0; oeop only on CRC bit 15.
- Reset mid-frame discards the partial frame. The next accepted byte starts a fresh frame with osop, reseeded scrambler and reinitialised CRC.

## Timing
**Reset values**
- ordy = 1
- oval = 0, odat = 0, osop = 0, oeop = 0, obusy = 0
- FSM = IDLE, holding register empty

**Latency**
- Byte accepted at edge N → its first bit is on odat with oval = 1 after edge N+1, if the shifter was idle.

**Throughput**
- 1 bit/clk with irdy held high.
- Frame length = 8*pPAYLOAD_BYTES+16 transfers.

**Stall rule**
- While oval && !irdy, odat/osop/oeop/oval hold their values.
- The scrambler, CRC and counters advance only on transfer.

**Input handshake**
- ordy does not depend combinationally on ival.
- A byte offered while ordy = 0 is not consumed.

## Configuration
- FRAME_SCR_EN defined: payload bits are XORed with the PRBS as above.
- FRAME_SCR_EN undefined: the scrambler is removed. Payload bits pass unmodified and the CRC is computed over the raw payload bits.

## Test plan
1. FRAME_SCR_EN undefined, pPAYLOAD_BYTES=9, input ASCII "123456789", irdy=1 → output 72 bits 0x31..0x39 MSB-first, then 16 bits 0x29B1. osop on bit 0, oeop on bit 87, 88 consecutive oval cycles.
2. FRAME_SCR_EN defined, two frames of all-zero payload → each frame's payload bits equal the PRBS model seeded with pSCR_SEED. Both frames are bit-identical, confirming reseed. The CRC matches the model over the scrambled bits.
3. Random irdy (50%) and random ival gaps over 3 back-to-back frames → output sequence identical to the irdy=1 run. No bit is lost or duplicated. osop/oeop count = 3 each. osop immediately follows oeop when the next byte is pre-loaded.
4. irdy=0 for 20 cycles mid-payload → odat/oval/osop/oeop stable throughout. ordy stays 0 once the holding register fills. The stream resumes at the same bit.
5. rst asserted at byte 5 of a frame, then the test-1 vector is replayed → the outputs are at reset values during rst. The new frame exactly reproduces the test-1 output, CRC 0x29B1.
6. ival pulsed with ordy=0 (holding register full) → byte ignored. The next transfer carries the held byte, and the payload count is unchanged.
